int_req_ctrl: RTL and testbench

- Requester side of the CPU interrupt handshake. It collects three external interrupt sources, synchronises them, edge-detects them and latches them as pending.
- It applies a mask and fixed priority, then issues a one-cycle break request (out_BK) with a 2-bit cause code to the interrupt handler.
- It holds the request in service until the handler returns the one-hot grant/clear vector (in_IG) on eret. This is the source of the handler's BK/code inputs and the consumer of its IG output.

---
 rtl/int_req_ctrl.sv | 156 +++++++++++++++
 tb/tb_int_req_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_req_ctrl.sv
// int_req_ctrl: interrupt requester. It synchronises and edge-detects three sources, then issues prioritised BK/code requests.
// It holds each request until the handler's IG grant arrives. Define INT_TIMEOUT_EN to enable the service watchdog (out_err).
module int_req_ctrl #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned EDGE_MODE   = 1,
   parameter int unsigned TIMEOUT     = 1024
) (
   input  logic       in_CLK,
   input  logic       in_RST_N,
   input  logic [2:0] in_irq,
   input  logic [2:0] in_mask,
   input  logic       in_IE,
   input  logic [3:0] in_IG,
   output logic       out_BK,
   output logic [1:0] out_code,
   output logic [2:0] out_pend,
   output logic       out_busy,
   output logic       out_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_e;

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   state_e     state_q;
   logic [2:0] sync_q [SYNC_STAGES];
   logic [2:0] sync_last;
   logic [2:0] hist_q;
   logic [2:0] pend_q, pend_d;
   logic [2:0] set_vec, clr_vec;
   logic [2:0] elig;
   logic [2:0] svc_sel;
   logic [1:0] code_q;
   logic [1:0] prio_code;
   logic       bk_q;
   logic       busy_q;
   logic       grant_hit;
   logic       expire;
   logic       unused_sig;

   assign sync_last = sync_q[SYNC_STAGES-1];

   always_comb begin
      set_vec   = (EDGE_MODE != 0) ? (sync_last & ~hist_q) : sync_last;
      svc_sel   = {code_q == 2'd3, code_q == 2'd2, code_q == 2'd1};
      grant_hit = (state_q == SERVICE) && (|(in_IG[2:0] & svc_sel));
      elig      = pend_q & in_mask;
      if (elig[2]) begin
         prio_code = 2'd3;
      end else if (elig[1]) begin
         prio_code = 2'd2;
      end else begin
         prio_code = 2'd1;
      end
      clr_vec = in_IG[2:0];
      if (expire) begin
         clr_vec = clr_vec | svc_sel;
      end
      // a fresh set in the same cycle as its clear keeps the bit pending
      pend_d = (pend_q & ~clr_vec) | set_vec;
   end

   always_ff @(posedge in_CLK or negedge in_RST_N) begin
      if (!in_RST_N) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         hist_q <= '0;
         pend_q <= '0;
      end else begin
         sync_q[0] <= in_irq;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         hist_q <= sync_last;
         pend_q <= pend_d;
      end
   end

   always_ff @(posedge in_CLK or negedge in_RST_N) begin
      if (!in_RST_N) begin
         state_q <= IDLE;
         code_q  <= '0;
         bk_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_IE && (|elig)) begin
                  code_q  <= prio_code;
                  bk_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= REQ;
               end
            end
            REQ: begin
               bk_q    <= 1'b0;
               state_q <= SERVICE;
            end
            SERVICE: begin
               if (grant_hit || expire) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               bk_q    <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef INT_TIMEOUT_EN
   logic [CNT_W-1:0] to_cnt_q;
   logic             err_q;

   // a grant on the expiry cycle wins, so it completes normally
   assign expire = (state_q == SERVICE) && !grant_hit &&
                   (to_cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge in_CLK or negedge in_RST_N) begin
      if (!in_RST_N) begin
         to_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state_q != SERVICE) begin
            to_cnt_q <= '0;
         end else begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
         end
         if (expire) begin
            err_q <= 1'b1;
         end
      end
   end

   assign out_err    = err_q;
   assign unused_sig = in_IG[3];
`else
   assign expire     = 1'b0;
   assign out_err    = 1'b0;
   assign unused_sig = ^{in_IG[3], CNT_W[0]};
`endif

   assign out_BK   = bk_q;
   assign out_code = code_q;
   assign out_pend = pend_q;
   assign out_busy = busy_q;

endmodule

// File: tb/tb_int_req_ctrl.sv
// tb_int_req_ctrl: directed and random stimulus for int_req_ctrl, checked every cycle against a cycle-level behavioural model.
// Define INT_TIMEOUT_EN to exercise the watchdog with TIMEOUT = 8.
module tb_int_req_ctrl;

   localparam int unsigned S = 2;
`ifdef INT_TIMEOUT_EN
   localparam int unsigned TB_TO = 8;
`else
   localparam int unsigned TB_TO = 1024;
`endif

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] irq   = '0;
   logic [2:0] mask  = '0;
   logic       ie    = 1'b0;
   logic [3:0] ig    = '0;
   logic       bk;
   logic [1:0] code;
   logic [2:0] pend;
   logic       busy;
   logic       err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   int_req_ctrl #(
      .SYNC_STAGES(S),
      .EDGE_MODE(1),
      .TIMEOUT(TB_TO)
   ) dut (
      .in_CLK(clk),
      .in_RST_N(rst_n),
      .in_irq(irq),
      .in_mask(mask),
      .in_IE(ie),
      .in_IG(ig),
      .out_BK(bk),
      .out_code(code),
      .out_pend(pend),
      .out_busy(busy),
      .out_err(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: raw samples pass through an S-deep delay line, a 0->1 step sets pending,
   // and one request at a time is tracked by its age (0 = BK cycle, then service cycles).
   logic [2:0] m_hist [0:S];
   logic [2:0] m_pend = '0;
   logic [1:0] m_code = '0;
   logic       m_busy = 1'b0;
   logic       m_err  = 1'b0;
   int         m_age  = 0;
   logic [2:0] m_set, m_clr, m_old, m_el;

   initial begin
      for (int i = 0; i <= S; i++) m_hist[i] = '0;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= S; i++) m_hist[i] = '0;
         m_pend = '0;
         m_code = '0;
         m_busy = 1'b0;
         m_err  = 1'b0;
         m_age  = 0;
      end else begin
         m_set = m_hist[S-1] & ~m_hist[S];
         for (int i = S; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = irq;
         m_old = m_pend;
         m_clr = ig[2:0];
         m_el  = m_old & mask;
         if (m_busy) begin
            if (m_age == 0) begin
               m_age = 1;
            end else if (ig[m_code - 2'd1]) begin
               m_busy = 1'b0;
`ifdef INT_TIMEOUT_EN
            end else if (m_age == int'(TB_TO)) begin
               m_busy = 1'b0;
               m_err  = 1'b1;
               m_clr[m_code - 2'd1] = 1'b1;
`endif
            end else begin
               m_age++;
            end
         end else if (ie && m_el != 3'b000) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_code = m_el[2] ? 2'd3 : (m_el[1] ? 2'd2 : 2'd1);
         end
         m_pend = (m_old & ~m_clr) | m_set;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("mdl_bk",   bk,   (m_busy && m_age == 0));
         chk("mdl_code", code, m_code);
         chk("mdl_pend", pend, m_pend);
         chk("mdl_busy", busy, m_busy);
         chk("mdl_err",  err,  m_err);
      end
   end

   task automatic wait_bk(input string name);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         @(negedge clk);
         if (bk) found = 1'b1;
      end
      chk(name, found, 1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, expected $finish");
      $fatal(1, "global timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_bk", bk, 1'b0);
      chk("rst_code", code, 2'b00);
      chk("rst_pend", pend, 3'b000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      #2 rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("idle_bk", bk, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_pend", pend, 3'b000);
      chk("idle_code", code, 2'b00);

      // single held source
      mask = 3'b111; ie = 1'b1; irq = 3'b010;
      repeat (S + 1) @(negedge clk);
      chk("s2_pend", pend, 3'b010);
      chk("s2_bk_early", bk, 1'b0);
      @(negedge clk);
      chk("s2_bk", bk, 1'b1);
      chk("s2_code", code, 2'b10);
      @(negedge clk);
      chk("s2_bk_pulse", bk, 1'b0);
      chk("s2_busy", busy, 1'b1);
      ig = 4'b0010;
      @(negedge clk);
      ig = '0;
      chk("s2_pend_clr", pend, 3'b000);
      chk("s2_busy_fall", busy, 1'b0);
      repeat (10) begin
         @(negedge clk);
         chk("s2_no_rebk", bk, 1'b0);
      end

      // two sources together: priority, then mandatory idle cycle
      irq = '0;
      repeat (5) @(negedge clk);
      irq = 3'b101;
      wait_bk("s3_bk1_seen");
      chk("s3_code1", code, 2'b11);
      @(negedge clk);
      ig = 4'b0100;
      @(negedge clk);
      ig = '0;
      chk("s3_busy_fall", busy, 1'b0);
      chk("s3_idle_bk", bk, 1'b0);
      chk("s3_pend_left", pend, 3'b001);
      @(negedge clk);
      chk("s3_bk2", bk, 1'b1);
      chk("s3_code2", code, 2'b01);
      @(negedge clk);
      ig = 4'b0001;
      @(negedge clk);
      ig = '0;
      chk("s3_pend_clr", pend, 3'b000);

      // masked source stays pending until unmasked
      irq = '0;
      repeat (5) @(negedge clk);
      mask = 3'b110;
      irq = 3'b001;
      @(negedge clk);
      irq = '0;
      repeat (6) @(negedge clk);
      chk("s4_pend", pend, 3'b001);
      chk("s4_no_bk", bk, 1'b0);
      chk("s4_no_busy", busy, 1'b0);
      mask = 3'b111;
      @(negedge clk);
      chk("s4_bk", bk, 1'b1);
      chk("s4_code", code, 2'b01);
      @(negedge clk);
      ig = 4'b0001;
      @(negedge clk);
      ig = '0;
      chk("s4_pend_clr", pend, 3'b000);

      // new edge landing on the grant edge keeps pending set
      repeat (3) @(negedge clk);
      irq = 3'b010;
      wait_bk("s5_bk1_seen");
      chk("s5_code1", code, 2'b10);
      irq = '0;
      repeat (4) @(negedge clk);
      irq = 3'b010;
      repeat (S) @(negedge clk);
      ig = 4'b0010;
      @(negedge clk);
      ig = '0;
      chk("s5_pend_kept", pend, 3'b010);
      chk("s5_busy_fall", busy, 1'b0);
      @(negedge clk);
      chk("s5_bk2", bk, 1'b1);
      chk("s5_code2", code, 2'b10);
      @(negedge clk);
      ig = 4'b0010;
      @(negedge clk);
      ig = '0;
      chk("s5_pend_clr", pend, 3'b000);

`ifdef INT_TIMEOUT_EN
      irq = '0;
      repeat (5) @(negedge clk);
      irq = 3'b100;
      wait_bk("to_bk_seen");
      chk("to_code", code, 2'b11);
      repeat (TB_TO) begin
         @(negedge clk);
         chk("to_busy_hold", busy, 1'b1);
      end
      @(negedge clk);
      chk("to_busy_fall", busy, 1'b0);
      chk("to_err", err, 1'b1);
      chk("to_pend2", pend[2], 1'b0);
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("to_err_rst", err, 1'b0);
      irq = '0;
      #2 rst_n = 1'b1;
`endif

      // random traffic with one mid-run reset
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 5) == 0) irq = 3'($urandom);
         if ($urandom_range(0, 40) == 0) mask = 3'($urandom);
         ie = ($urandom_range(0, 9) != 0);
         ig = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         if (c == 1500) #1 rst_n = 1'b0;
         if (c == 1503) #1 rst_n = 1'b1;
      end
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
